// File: rtl/acc_pkg.sv
// ----------------------------------------------------------------------------
// acc_pkg
// Shared definitions for the accumulator-machine controller:
//   - 3-bit opcodes understood by the external registered ALU
//   - 4-bit controller op codes carried in the instruction word
//   - controller FSM state encoding
//   - instruction field geometry (op in the top nibble, operand below it)
// ----------------------------------------------------------------------------
package acc_pkg;

    // Instruction field geometry. The op nibble sits directly above an
    // ADDR_W-bit operand, so the op field starts at bit ADDR_W.
    localparam int OP_W     = 4;
    localparam int ALU_OP_W = 3;
    localparam int OPND_LSB = 0;

    // ALU opcodes (what the ALU computes from accum and data)
    localparam logic [ALU_OP_W-1:0] ALU_PASS = 3'b000;  // accum
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b001;  // accum + data
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b010;  // accum - data
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b011;  // accum & data
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b100;  // accum | data
    localparam logic [ALU_OP_W-1:0] ALU_ABS  = 3'b101;  // |accum|
    localparam logic [ALU_OP_W-1:0] ALU_MUL  = 3'b110;  // low bits of accum * data
    localparam logic [ALU_OP_W-1:0] ALU_LOAD = 3'b111;  // data

    // Controller ops (top nibble with the MSB set); 0xB..0xE are NOPs
    localparam logic [OP_W-1:0] OP_STORE = 4'h8;
    localparam logic [OP_W-1:0] OP_JMP   = 4'h9;
    localparam logic [OP_W-1:0] OP_JZ    = 4'hA;
    localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_LOAD_IR = 3'd1,
        S_EXEC    = 3'd2,
        S_OPERAND = 3'd3,
        S_ALU     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    // Bit position of the op field for a given operand width
    function automatic int op_lsb(input int addr_w);
        return addr_w;
    endfunction

    // Ops 0x0..0x7 go to the ALU; their low three bits are the ALU opcode
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return ~op[OP_W-1];
    endfunction

endpackage

// File: rtl/acc_ctrl_decode.sv
// ----------------------------------------------------------------------------
// acc_ctrl_decode
// Purely combinational instruction decoder for acc_ctrl.
// Ports:
//   ir_i        instruction register (op nibble above ADDR_W operand bits)
//   is_alu_o    op 0x0..0x7: ALU operation
//   is_store_o  STORE accum to dmem[operand]
//   is_jmp_o    unconditional jump to operand
//   is_jz_o     jump to operand when the ALU zero flag is set
//   is_halt_o   enter the halted state
//   alu_op_o    ALU opcode for ALU operations (low three op bits)
// Any op that is none of the above (0xB..0xE) decodes as a NOP.
// ----------------------------------------------------------------------------
module acc_ctrl_decode
    import acc_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic [OP_W+ADDR_W-1:0] ir_i,
    output logic                   is_alu_o,
    output logic                   is_store_o,
    output logic                   is_jmp_o,
    output logic                   is_jz_o,
    output logic                   is_halt_o,
    output logic [ALU_OP_W-1:0]    alu_op_o
);

    logic [OP_W-1:0] op;

    assign op = ir_i[op_lsb(ADDR_W) +: OP_W];

    assign is_alu_o   = is_alu_op(op);
    assign is_store_o = (op == OP_STORE);
    assign is_jmp_o   = (op == OP_JMP);
    assign is_jz_o    = (op == OP_JZ);
    assign is_halt_o  = (op == OP_HALT);
    assign alu_op_o   = op[ALU_OP_W-1:0];

endmodule

// File: rtl/acc_ctrl.sv
// ----------------------------------------------------------------------------
// acc_ctrl
// Accumulator-machine controller driving an external 8-bit registered ALU.
// It fetches instructions from a sync-read instruction memory, operands from
// a sync-read/sync-write data memory, owns PC and accumulator, and executes
// ALU ops, STORE, JMP, JZ and HALT.
// Ports:
//   clk, reset     single clock; synchronous active-high reset
//   imem_addr      instruction address (= pc)
//   imem_rdata     instruction, valid one cycle after imem_addr
//   dmem_addr      data address (= operand field of ir)
//   dmem_rdata     read data, valid one cycle after dmem_addr
//   dmem_we        write strobe, high only in the execute cycle of STORE
//   dmem_wdata     write data (= accum)
//   alu_opcode     registered ALU opcode; PASS except while an ALU op runs
//   alu_data       registered ALU data operand
//   accum          accumulator, also the ALU accum input
//   alu_out        ALU result, one cycle after the ALU inputs
//   zero           ALU flag: registered (accum == 0)
//   halted         high in the halted state
//   instr_done     one-cycle pulse in the last cycle of every instruction
// Cycle budget: ALU op = FETCH, LOAD_IR, EXEC, OPERAND, ALU, WB (6 cycles);
// every other instruction = FETCH, LOAD_IR, EXEC (3 cycles).
// ----------------------------------------------------------------------------
module acc_ctrl
    import acc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [OP_W+ADDR_W-1:0]   imem_rdata,
    output logic [ADDR_W-1:0]        dmem_addr,
    input  logic [DATA_W-1:0]        dmem_rdata,
    output logic                     dmem_we,
    output logic [DATA_W-1:0]        dmem_wdata,
    output logic [ALU_OP_W-1:0]      alu_opcode,
    output logic signed [DATA_W-1:0] alu_data,
    output logic signed [DATA_W-1:0] accum,
    input  logic signed [DATA_W-1:0] alu_out,
    input  logic                     zero,
    output logic                     halted,
    output logic                     instr_done
);

    localparam int IW = OP_W + ADDR_W;

    state_t                    state_q;
    logic [ADDR_W-1:0]         pc_q;
    logic [IW-1:0]             ir_q;
    logic signed [DATA_W-1:0]  accum_q;
    logic [ALU_OP_W-1:0]       alu_opcode_q;
    logic signed [DATA_W-1:0]  alu_data_q;

    logic                      dec_is_alu;
    logic                      dec_is_store;
    logic                      dec_is_jmp;
    logic                      dec_is_jz;
    logic                      dec_is_halt;
    logic [ALU_OP_W-1:0]       dec_alu_op;
    logic [ADDR_W-1:0]         operand;

    acc_ctrl_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .ir_i       (ir_q),
        .is_alu_o   (dec_is_alu),
        .is_store_o (dec_is_store),
        .is_jmp_o   (dec_is_jmp),
        .is_jz_o    (dec_is_jz),
        .is_halt_o  (dec_is_halt),
        .alu_op_o   (dec_alu_op)
    );

    assign operand = ir_q[OPND_LSB +: ADDR_W];

    // ------------------------------------------------------------------
    // Controller FSM. All architectural state (pc, ir, accum, ALU input
    // registers) is updated here so that a reset in any state discards the
    // instruction in flight without a partial writeback.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            ir_q         <= '0;
            accum_q      <= '0;
            alu_opcode_q <= ALU_PASS;
            alu_data_q   <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // imem_addr = pc is presented this cycle; the memory
                    // returns the word during S_LOAD_IR.
                    state_q <= S_LOAD_IR;
                end

                S_LOAD_IR: begin
                    ir_q    <= imem_rdata;
                    pc_q    <= pc_q + 1'b1;   // wraps naturally at 2**ADDR_W
                    state_q <= S_EXEC;
                end

                S_EXEC: begin
                    if (dec_is_alu) begin
                        // dmem_addr = operand now; data arrives in S_OPERAND
                        state_q <= S_OPERAND;
                    end else if (dec_is_halt) begin
                        state_q <= S_HALT;
                    end else begin
                        // zero was registered from accum at least two edges
                        // after the last accum update, so it is current here.
                        if (dec_is_jmp || (dec_is_jz && zero)) begin
                            pc_q <= operand;
                        end
                        state_q <= S_FETCH;
                    end
                end

                S_OPERAND: begin
                    alu_data_q   <= dmem_rdata;
                    alu_opcode_q <= dec_alu_op;
                    state_q      <= S_ALU;
                end

                S_ALU: begin
                    // Inputs held stable; the ALU captures its result at
                    // this edge and presents it during S_WB.
                    state_q <= S_WB;
                end

                S_WB: begin
                    accum_q      <= alu_out;
                    // Back to PASS so the idle ALU output tracks accum
                    alu_opcode_q <= ALU_PASS;
                    state_q      <= S_FETCH;
                end

                S_HALT: begin
                    state_q <= S_HALT;
                end

                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_addr  = pc_q;
    assign dmem_addr  = operand;
    assign dmem_wdata = accum_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_data   = alu_data_q;
    assign accum      = accum_q;
    assign halted     = (state_q == S_HALT);

    // Gated by reset: an instruction interrupted by reset neither writes
    // memory nor reports completion.
    assign dmem_we    = ~reset && (state_q == S_EXEC) && dec_is_store;
    assign instr_done = ~reset &&
                        ((state_q == S_WB) ||
                         ((state_q == S_EXEC) && !dec_is_alu));

endmodule

// File: tb/tb_acc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_acc_ctrl
// Bench for acc_ctrl. Supplies instruction/data memories and a registered
// ALU, runs directed programs with literal expectations, then random
// programs with random mid-run resets. An instruction-level model (program
// counter, accumulator, data memory, per-instruction latency) predicts the
// controller outputs on every cycle.
// ----------------------------------------------------------------------------
module tb_acc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] imem_addr;
    logic [7:0] imem_rdata;
    logic [3:0] dmem_addr;
    logic [7:0] dmem_rdata;
    logic       dmem_we;
    logic [7:0] dmem_wdata;
    logic [2:0] alu_opcode;
    logic [7:0] alu_data;
    logic [7:0] accum;
    logic [7:0] alu_out;
    logic       zero;
    logic       halted;
    logic       instr_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] prog_img [16];
    logic [7:0] data_img [16];
    logic [7:0] dmem     [16];

    acc_ctrl #(
        .DATA_W (8),
        .ADDR_W (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem_addr  (dmem_addr),
        .dmem_rdata (dmem_rdata),
        .dmem_we    (dmem_we),
        .dmem_wdata (dmem_wdata),
        .alu_opcode (alu_opcode),
        .alu_data   (alu_data),
        .accum      (accum),
        .alu_out    (alu_out),
        .zero       (zero),
        .halted     (halted),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    // Arithmetic of the 8-bit ALU, two's complement, truncated
    function automatic logic [7:0] alu_f(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] d);
        logic [15:0] p;
        p = 16'(a) * 16'(d);
        case (op)
            3'd0:    return a;
            3'd1:    return a + d;
            3'd2:    return a - d;
            3'd3:    return a & d;
            3'd4:    return a | d;
            3'd5:    return a[7] ? 8'(~a + 8'd1) : a;
            3'd6:    return p[7:0];
            default: return d;
        endcase
    endfunction

    // Memories and registered ALU. Data memory reloads from its image
    // while reset is held.
    always @(posedge clk) begin
        imem_rdata <= prog_img[imem_addr];
        dmem_rdata <= dmem[dmem_addr];
        if (reset) begin
            for (int i = 0; i < 16; i++) dmem[i] <= data_img[i];
            alu_out <= 8'd0;
            zero    <= 1'b1;
        end else begin
            if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
            alu_out <= alu_f(alu_opcode, accum, alu_data);
            zero    <= (accum == 8'd0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Instruction-level model and per-cycle comparison
    // ------------------------------------------------------------------
    logic [3:0] m_pc;
    logic [7:0] m_acc;
    logic       m_halt;
    logic [7:0] m_dmem [16];
    logic [7:0] cur;
    int         cyc;

    initial begin : compare
        logic [3:0] op;
        logic [3:0] opnd;
        logic [3:0] nxt;
        logic       alu_instr;
        int         lat;
        m_pc = 4'd0; m_acc = 8'd0; m_halt = 1'b0; cyc = 0; cur = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("we_in_reset", 32'(dmem_we), 32'd0);
                chk("done_in_reset", 32'(instr_done), 32'd0);
                m_pc = 4'd0; m_acc = 8'd0; m_halt = 1'b0; cyc = 0;
                for (int i = 0; i < 16; i++) m_dmem[i] = data_img[i];
            end else if (m_halt) begin
                chk("halt_halted", 32'(halted), 32'd1);
                chk("halt_done", 32'(instr_done), 32'd0);
                chk("halt_we", 32'(dmem_we), 32'd0);
                chk("halt_accum", 32'(accum), 32'(m_acc));
                chk("halt_opcode", 32'(alu_opcode), 32'd0);
                chk("halt_pc", 32'(imem_addr), 32'(m_pc));
            end else begin
                cyc++;
                if (cyc == 1) begin
                    cur = prog_img[m_pc];
                    chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
                end
                op        = cur[7:4];
                opnd      = cur[3:0];
                alu_instr = !op[3];
                lat       = alu_instr ? 6 : 3;
                chk("accum", 32'(accum), 32'(m_acc));
                chk("halted", 32'(halted), 32'd0);
                chk("instr_done", 32'(instr_done), 32'(cyc == lat));
                chk("dmem_we", 32'(dmem_we), 32'(cyc == lat && op == 4'h8));
                chk("alu_opcode", 32'(alu_opcode),
                    (alu_instr && cyc >= 5) ? 32'(op[2:0]) : 32'd0);
                if (alu_instr && cyc >= 5)
                    chk("alu_data", 32'(alu_data), 32'(m_dmem[opnd]));
                if (cyc == 3) begin
                    chk("dmem_addr", 32'(dmem_addr), 32'(opnd));
                    if (op == 4'h8) chk("dmem_wdata", 32'(dmem_wdata), 32'(m_acc));
                end
                if (cyc == lat) begin
                    nxt = m_pc + 4'd1;
                    if (alu_instr)                       m_acc = alu_f(op[2:0], m_acc, m_dmem[opnd]);
                    else if (op == 4'h8)                 m_dmem[opnd] = m_acc;
                    else if (op == 4'h9)                 nxt = opnd;
                    else if (op == 4'hA && m_acc == 0)   nxt = opnd;
                    else if (op == 4'hF)                 m_halt = 1'b1;
                    m_pc = nxt;
                    cyc  = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic hold_reset();
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prog_img[i] = 8'hF0;
            data_img[i] = 8'h00;
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic wait_done(input int n, input string tag);
        int got = 0;
        for (int c = 0; c < 400 && got < n; c++) begin
            @(negedge clk);
            if (instr_done) got++;
        end
        chk(tag, 32'(got), 32'(n));
    endtask

    task automatic wait_halt(output int ncyc, output int ndone);
        ncyc = 0; ndone = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (halted) break;
            ncyc++;
            if (instr_done) ndone++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    function automatic logic [7:0] rand_instr();
        int r;
        r = $urandom_range(0, 99);
        if (r < 50)      return {1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
        else if (r < 60) return {4'h8, 4'($urandom_range(0, 15))};
        else if (r < 70) return {4'h9, 4'($urandom_range(0, 15))};
        else if (r < 82) return {4'hA, 4'($urandom_range(0, 15))};
        else if (r < 86) return 8'hF0;
        else             return {4'($urandom_range(11, 14)), 4'($urandom_range(0, 15))};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : driver
        int ncyc, ndone, k, rst_at;

        // 1: LOAD 0, ADD 1, STORE 2, HALT
        hold_reset();
        data_img[0] = 8'd5; data_img[1] = 8'd3;
        prog_img[0] = 8'h70; prog_img[1] = 8'h11; prog_img[2] = 8'h82; prog_img[3] = 8'hF0;
        release_reset();
        chk("t1_reset_accum", 32'(accum), 32'd0);
        chk("t1_reset_pc", 32'(imem_addr), 32'd0);
        wait_halt(ncyc, ndone);
        chk("t1_cycles", 32'(ncyc), 32'd18);
        chk("t1_done_pulses", 32'(ndone), 32'd4);
        chk("t1_accum", 32'(accum), 32'd8);
        chk("t1_dmem2", 32'(dmem[2]), 32'd8);
        $display("txn t1 add/store/halt: cycles=%0d done=%0d accum=%0d", ncyc, ndone, accum);

        // 2: LOAD 0, SUB 0, JZ 9 -> taken
        hold_reset();
        data_img[0] = 8'd7;
        prog_img[0] = 8'h70; prog_img[1] = 8'h20; prog_img[2] = 8'hA9;
        release_reset();
        wait_done(3, "t2_done_count");
        @(negedge clk);
        chk("t2_jz_taken_addr", 32'(imem_addr), 32'd9);
        chk("t2_accum", 32'(accum), 32'd0);
        $display("txn t2 jz taken: fetch=%0d accum=%0d", imem_addr, accum);

        // 3: accum=5, JZ 9 at pc=3 -> not taken
        hold_reset();
        data_img[0] = 8'd5;
        prog_img[0] = 8'h70; prog_img[1] = 8'hB0; prog_img[2] = 8'hB0; prog_img[3] = 8'hA9;
        prog_img[4] = 8'hF0;
        release_reset();
        wait_done(4, "t3_done_count");
        @(negedge clk);
        chk("t3_jz_not_taken_addr", 32'(imem_addr), 32'd4);
        chk("t3_accum", 32'(accum), 32'd5);
        $display("txn t3 jz not taken: fetch=%0d", imem_addr);

        // 4: JMP 15, NOP at 15 -> wraps to 0
        hold_reset();
        prog_img[0] = 8'h9F; prog_img[15] = 8'hB0;
        release_reset();
        wait_done(1, "t4_jmp_done");
        k = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            k++;
            if (instr_done) break;
        end
        chk("t4_nop_cycles", 32'(k), 32'd3);
        @(negedge clk);
        chk("t4_wrap_addr", 32'(imem_addr), 32'd0);
        $display("txn t4 jmp/nop wrap: nop_cycles=%0d fetch=%0d", k, imem_addr);

        // 5: MUL and ABS edge cases
        hold_reset();
        data_img[0] = 8'hF8; data_img[1] = 8'd20; data_img[2] = 8'h80;
        prog_img[0] = 8'h70; prog_img[1] = 8'h61; prog_img[2] = 8'h72; prog_img[3] = 8'h50;
        release_reset();
        wait_done(2, "t5_done_count");
        @(negedge clk);
        chk("t5_mul", 32'(accum), 32'h60);
        wait_halt(ncyc, ndone);
        chk("t5_abs", 32'(accum), 32'h80);
        $display("txn t5 mul/abs: accum=0x%0h", accum);

        // 6: reset during S_ALU of an ADD
        hold_reset();
        data_img[0] = 8'd5;
        prog_img[0] = 8'h70; prog_img[1] = 8'h10;
        release_reset();
        wait_done(1, "t6_load_done");
        repeat (5) @(posedge clk);
        #1;
        chk("t6_in_alu_opcode", 32'(alu_opcode), 32'd1);
        chk("t6_in_alu_data", 32'(alu_data), 32'd5);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_accum", 32'(accum), 32'd0);
        chk("t6_pc", 32'(imem_addr), 32'd0);
        chk("t6_opcode", 32'(alu_opcode), 32'd0);
        chk("t6_we", 32'(dmem_we), 32'd0);
        chk("t6_done", 32'(instr_done), 32'd0);
        chk("t6_halted", 32'(halted), 32'd0);
        $display("txn t6 reset in ALU: accum=%0d pc=%0d", accum, imem_addr);

        // Random programs with occasional mid-run reset
        for (int p = 0; p < 30; p++) begin
            hold_reset();
            for (int i = 0; i < 16; i++) begin
                prog_img[i] = rand_instr();
                data_img[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            end
            release_reset();
            rst_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 100)) : -1;
            for (int c = 0; c < 120; c++) begin
                @(posedge clk); #1;
                reset = (c == rst_at);
            end
            $display("txn random prog %0d: reset_at=%0d accum=0x%0h halted=%0d",
                     p, rst_at, accum, halted);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
